data_memory_dumper: RTL and testbench
=====================================

// Module: data_memory_dumper
// PURPOSE
// Debug read-out engine on the snoop port (port B) of the data memory.
// On a start pulse, walks every word of the memory and streams it as bytes over a
// valid/ready byte interface to the UART TX, with framing header and checksum.
// Sits between data memory port B (async read) and the external UART transmitter.
// PARAMETERS
// DEPTH     256    number of 32-bit words to dump (>=1); word counter width max(1,$clog2(DEPTH))
// PORTS
// clk_i       in   1   system clock
// rst_i       in   1   synchronous, active-high reset
// start_i     in   1   one-cycle dump request; ignored unless IDLE
// busy_o      out  1   high in every state except IDLE
// done_o      out  1   one-cycle pulse after checksum byte accepted
// mem_addr_o  out  32  byte address to memory port B: {word_idx, 2'b00}, zero-extended
// mem_data_i  in   32  async read data from memory port B
// tx_data_o   out  8   byte to UART TX
// tx_valid_o  out  1   byte valid
// tx_ready_i  in   1   UART TX accepts byte; transfer when tx_valid_o && tx_ready_i
// BEHAVIOUR
// Reset: state IDLE; busy_o, done_o, tx_valid_o = 0; tx_data_o = 0; mem_addr_o = 0; counters, checksum = 0.
// Frame: 0xDA header, then DEPTH words LSB-first (4 bytes each), then 1 checksum byte;
//   total 4*DEPTH+2 bytes. Checksum = sum of all data bytes mod 256 (header excluded).
// FSM:
//   IDLE     -> HEADER on start_i; clear word_idx, byte_idx, checksum.
//   HEADER   tx_valid_o=1, data 0xDA; on handshake -> LOAD.
//   LOAD     tx_valid_o=0; mem_addr_o reflects word_idx; capture mem_data_i into word_q; -> SEND.
//   SEND     tx_valid_o=1, data = word_q byte[byte_idx]; on handshake add byte to checksum,
//            byte_idx++. After byte 3: byte_idx=0; if word_idx==DEPTH-1 -> CHECKSUM,
//            else word_idx++ -> LOAD.
//   CHECKSUM tx_valid_o=1, data = checksum; on handshake -> DONE.
//   DONE     done_o=1 for this cycle only; -> IDLE.
// Handshake: once tx_valid_o is high, tx_valid_o and tx_data_o hold stable until accepted;
//   no byte dropped or repeated under any tx_ready_i pattern. tx_data_o/valid are registered.
// Timing (tx_ready_i tied 1, start_i at cycle 0): header valid at cycle 1; each word costs
//   5 cycles; checksum at cycle 5*DEPTH+2; done_o at cycle 5*DEPTH+3.
// Coherence: each word reflects memory content in its LOAD cycle; concurrent core writes
//   to words not yet loaded appear in the dump; no further ordering guarantee.
// Boundaries:
//   start_i while busy: ignored, current frame unaffected.
//   start_i in DONE cycle: ignored (only IDLE accepts).
//   DEPTH=1: single LOAD/SEND pass, then CHECKSUM.
//   Checksum and word_idx wrap modulo their widths; word_idx never exceeds DEPTH-1.
//   rst_i mid-frame: abort at that edge, all outputs to reset values; partial frame is
//   not completed; no done_o pulse.
// STRUCTURE
// Package dumper_pkg: state enum (IDLE, HEADER, LOAD, SEND, CHECKSUM, DONE),
//   localparam DUMP_HEADER = 8'hDA.
// No sub-module: FSM, word/byte counters, word_q and checksum in one module; UART TX is external.
// TESTING
// 1 DEPTH=4, words 0x03020100,0x07060504,0x0B0A0908,0x0F0E0D0C, ready=1 -> bytes DA,00..0F,78;
//   done_o at cycle 23; busy_o high cycles 1..23.
// 2 Same memory, tx_ready_i low 10 cycles mid-word then random -> identical 18-byte stream,
//   tx_data_o stable while valid && !ready.
// 3 All words 0xFFFFFFFF, DEPTH=4 -> 16 bytes FF, checksum 0xF0.
// 4 start_i pulsed at cycles 3 and 10 during frame -> exactly one frame, one done_o.
// 5 rst_i at cycle 8 mid-SEND -> outputs zero next cycle, no done_o;
//   new start_i gives full frame from header.
// 6 Check mem_addr_o = 0,4,8,12 in LOAD cycles; core write 0xDEADBEEF to word 3 during
//   word 0 -> dump shows EF,BE,AD,DE for word 3.

Source files
------------

// File: rtl/dumper_pkg.sv
// Shared definitions for the data memory dump engine: FSM encoding and frame constants.
package dumper_pkg;

  // FSM state encoding, kept as plain constants so legacy tools can consume it.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_HEADER   = 3'd1;
  localparam state_t ST_LOAD     = 3'd2;
  localparam state_t ST_SEND     = 3'd3;
  localparam state_t ST_CHECKSUM = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

  // First byte of every dump frame; lets the host resynchronise on the stream.
  localparam logic [7:0] DUMP_HEADER = 8'hDA;

endpackage

// File: rtl/data_memory_dumper.sv
// Debug read-out engine: on start, walks every word of the data memory through the
// snoop port and streams it LSB-first as bytes to the UART TX, framed by a header
// byte and trailed by an 8-bit additive checksum of the data bytes.
module data_memory_dumper
  import dumper_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  state_t        state_reg;
  logic [AW-1:0] word_idx_reg;
  logic [1:0]    byte_idx_reg;
  logic [31:0]   word_q_reg;
  logic [7:0]    checksum_reg;
  logic [7:0]    tx_data_reg;
  logic          tx_valid_reg;
  logic          done_reg;

  logic [1:0]    byte_idx_inc;
  logic [7:0]    checksum_next;
  logic          tx_fire;
  logic [7:0]    word_bytes [4];

  // Split the captured word into byte lanes so SEND can pick the next one by index.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign word_bytes[gi] = word_q_reg[8*gi +: 8];
    end
  endgenerate

  assign byte_idx_inc  = byte_idx_reg + 2'd1;
  assign checksum_next = checksum_reg + tx_data_reg;
  assign tx_fire       = tx_valid_reg && tx_ready_i;

  assign busy_o     = (state_reg != ST_IDLE);
  assign done_o     = done_reg;
  assign tx_data_o  = tx_data_reg;
  assign tx_valid_o = tx_valid_reg;
  // Word index drives the snoop port continuously; it is only meaningful in LOAD.
  assign mem_addr_o = {{(30 - AW){1'b0}}, word_idx_reg, 2'b00};

  // Frame sequencer: state, counters, checksum and the registered TX byte all move
  // together so the byte/valid pair stays stable until the UART accepts it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      word_q_reg   <= '0;
      checksum_reg <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg    <= ST_HEADER;
            word_idx_reg <= '0;
            byte_idx_reg <= '0;
            checksum_reg <= '0;
            tx_data_reg  <= DUMP_HEADER;
            tx_valid_reg <= 1'b1;
          end
        end

        ST_HEADER: begin
          if (tx_fire) begin
            state_reg    <= ST_LOAD;
            tx_valid_reg <= 1'b0;
          end
        end

        // Memory is sampled here, so later core writes to this word are not seen.
        ST_LOAD: begin
          word_q_reg   <= mem_data_i;
          tx_data_reg  <= mem_data_i[7:0];
          tx_valid_reg <= 1'b1;
          state_reg    <= ST_SEND;
        end

        ST_SEND: begin
          if (tx_fire) begin
            checksum_reg <= checksum_next;
            byte_idx_reg <= byte_idx_inc;
            if (byte_idx_reg == 2'd3) begin
              if (word_idx_reg == LAST_WORD) begin
                // Checksum byte already includes the byte being accepted now.
                state_reg   <= ST_CHECKSUM;
                tx_data_reg <= checksum_next;
              end else begin
                state_reg    <= ST_LOAD;
                word_idx_reg <= word_idx_reg + 1'b1;
                tx_valid_reg <= 1'b0;
              end
            end else begin
              tx_data_reg <= word_bytes[byte_idx_inc];
            end
          end
        end

        ST_CHECKSUM: begin
          if (tx_fire) begin
            state_reg    <= ST_DONE;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            done_reg     <= 1'b1;
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg    <= ST_IDLE;
          tx_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_dumper.sv
// Scoreboard bench for data_memory_dumper (DEPTH=4): stimulus pushes the expected
// byte stream, a negedge monitor pops and compares every accepted byte.
module tb_data_memory_dumper;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        tx_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;

  logic [31:0] mem [DEPTH];
  logic [7:0]  exp_q [$];
  logic [31:0] addr_seen [$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  data_memory_dumper #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Asynchronous memory port B model.
  always_comb mem_data_i = mem[mem_addr_o[3:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  always @(negedge clk_i) begin
    if (prev_stall) begin
      check("hold_valid", 32'(tx_valid_o), 32'd1);
      check("hold_data", 32'(tx_data_o), 32'(prev_data));
    end
    if (tx_valid_o && tx_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("stream_byte", 32'(tx_data_o), 32'(e));
        $display("[TB] byte 0x%02h (expected 0x%02h)", tx_data_o, e);
      end
    end
    if (done_o) done_cnt++;
    prev_stall = tx_valid_o && !tx_ready_i;
    prev_data  = tx_data_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_frame();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3,
                            input logic [7:0] cs);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    exp_q.push_back(8'hDA);
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(w[i][8*b +: 8]);
    exp_q.push_back(cs);
  endtask

  task automatic wait_done(input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_i);
      #1;
      if (done_o) found = 1'b1;
    end
    check("done_seen", 32'(found), 32'd1);
    tick();
  endtask

  task automatic load_counting();
    mem[0] = 32'h03020100; mem[1] = 32'h07060504;
    mem[2] = 32'h0B0A0908; mem[3] = 32'h0F0E0D0C;
  endtask

  initial begin
    int d0;
    logic found;
    load_counting();
    tick(); tick(); tick();
    // Reset state
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_valid", 32'(tx_valid_o), 32'd0);
    check("rst_data", 32'(tx_data_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // 1: basic frame, exact cycle timing of busy/done
    push_frame(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 8'h78);
    start_frame();
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk_i);
      check($sformatf("t1_busy_c%0d", k), 32'(busy_o), (k <= 23) ? 32'd1 : 32'd0);
      check($sformatf("t1_done_c%0d", k), 32'(done_o), (k == 23) ? 32'd1 : 32'd0);
      tick();
    end
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: back-pressure, long stall mid-word then random ready
    push_frame(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 8'h78);
    start_frame();
    repeat (3) tick();
    tx_ready_i = 1'b0;
    repeat (10) tick();
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tx_ready_i = 1'($urandom_range(0, 1));
      tick();
      if (done_o) found = 1'b1;
    end
    tx_ready_i = 1'b1;
    check("t2_done_seen", 32'(found), 32'd1);
    tick();
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: all-ones memory, checksum wraps
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFFFFFF;
    push_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hF0);
    start_frame();
    wait_done(100);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: start while busy is ignored
    load_counting();
    push_frame(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 8'h78);
    d0 = done_cnt;
    start_frame();
    tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (6) tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    wait_done(100);
    repeat (40) tick();
    check("t4_one_done", 32'(done_cnt - d0), 32'd1);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t4_idle", 32'(busy_o), 32'd0);

    // 5: reset mid-frame aborts, then a fresh frame runs from the header
    push_frame(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 8'h78);
    d0 = done_cnt;
    start_frame();
    repeat (6) tick();
    rst_i = 1'b1;
    tick();
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_valid", 32'(tx_valid_o), 32'd0);
    check("t5_data", 32'(tx_data_o), 32'd0);
    check("t5_addr", mem_addr_o, 32'd0);
    rst_i = 1'b0;
    exp_q.delete();
    repeat (30) tick();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    push_frame(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 8'h78);
    start_frame();
    wait_done(100);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: LOAD addresses and a core write to a word not yet loaded
    push_frame(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'hDEADBEEF, 8'h7A);
    d0 = done_cnt;
    start_frame();
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) mem[3] = 32'hDEADBEEF;
      if (busy_o && !tx_valid_o && !done_o) addr_seen.push_back(mem_addr_o);
      tick();
    end
    check("t6_load_count", 32'(addr_seen.size()), 32'd4);
    for (int i = 0; i < addr_seen.size() && i < 4; i++)
      check($sformatf("t6_addr%0d", i), addr_seen[i], 32'(4 * i));
    check("t6_one_done", 32'(done_cnt - d0), 32'd1);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
